// File: rtl/fetch_pc_unit.sv
// Program-counter and instruction-fetch stage: one outstanding imem request,
// valid/ready output buffer towards decode, PC-relative branch and absolute jump redirects.
module fetch_pc_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        br_taken,
    input  logic [15:0] br_base,
    input  logic [15:0] br_offset_sh,
    input  logic        jmp_valid,
    input  logic [15:0] jmp_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [15:0] inst_out,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_out
);

    typedef enum logic {
        FETCH    = 1'b0,
        WAIT_RSP = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] req_pc, req_pc_n;
    logic        discard, discard_n;
    logic        inst_valid_n;
    logic [15:0] inst_out_n;
    logic [15:0] inst_pc_n;

    logic        free;
    logic        redirect;
    logic        capture;
    logic [15:0] br_sum;
    logic [15:0] target;

    assign free      = !inst_valid || inst_ready;
    assign redirect  = jmp_valid || br_taken;
    assign br_sum    = br_base + br_offset_sh;
    assign target    = jmp_valid ? (jmp_target & 16'hFFFE) : (br_sum & 16'hFFFE);

    // Request is gated by reset_n so the bus stays idle while reset is held.
    assign imem_req  = reset_n && (state == FETCH) && free && !redirect;
    assign imem_addr = pc;
    assign pc_out    = pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_pc     <= RESET_PC;
            discard    <= 1'b0;
            inst_valid <= 1'b0;
            inst_out   <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_pc     <= req_pc_n;
            discard    <= discard_n;
            inst_valid <= inst_valid_n;
            inst_out   <= inst_out_n;
            inst_pc    <= inst_pc_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        req_pc_n     = req_pc;
        discard_n    = discard;
        inst_valid_n = inst_valid;
        inst_out_n   = inst_out;
        inst_pc_n    = inst_pc;
        capture      = 1'b0;

        case (state)
            FETCH: begin
                if (imem_req && imem_gnt) begin
                    state_n  = WAIT_RSP;
                    req_pc_n = pc;
                    pc_n     = pc + PC_INC;
                end
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    state_n   = FETCH;
                    discard_n = 1'b0;
                    capture   = !discard && !redirect;
                end
            end
            default: state_n = FETCH;
        endcase

        if (capture) begin
            inst_valid_n = 1'b1;
            inst_out_n   = imem_rdata;
            inst_pc_n    = req_pc;
        end else if (inst_valid && inst_ready) begin
            inst_valid_n = 1'b0;
        end

        // A redirect squashes the buffer and marks any in-flight response as wrong-path.
        if (redirect) begin
            pc_n         = target;
            inst_valid_n = 1'b0;
            if (state == WAIT_RSP && !imem_rvalid) begin
                discard_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a behavioural instruction memory of selectable latency.
module tb_fetch_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        br_taken;
    logic [15:0] br_base;
    logic [15:0] br_offset_sh;
    logic        jmp_valid;
    logic [15:0] jmp_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst_out;
    logic [15:0] inst_pc;
    logic [15:0] pc_out;

    int checks   = 0;
    int failures = 0;
    int lat      = 1;

    fetch_pc_unit #(
        .RESET_PC (16'h0100),
        .PC_INC   (16'd2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .br_taken     (br_taken),
        .br_base      (br_base),
        .br_offset_sh (br_offset_sh),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst_out     (inst_out),
        .inst_pc      (inst_pc),
        .pc_out       (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr ^ 16'h5A00, lat cycles after the grant; it is unaware of DUT reset.
    initial begin
        logic        active;
        int          cnt;
        logic [15:0] paddr;
        active      = 1'b0;
        cnt         = 0;
        paddr       = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            if (imem_req && imem_gnt) begin
                active = 1'b1;
                cnt    = lat;
                paddr  = imem_addr;
            end
            #1;
            imem_rvalid = 1'b0;
            if (active) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = paddr ^ 16'h5A00;
                    active      = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        br_taken     = 1'b0;
        br_base      = '0;
        br_offset_sh = '0;
        jmp_valid    = 1'b0;
        jmp_target   = '0;
        imem_gnt     = 1'b1;
        inst_ready   = 1'b0;

        // Reset values
        tick(); tick(); #1;
        chk("rst_req",   {15'd0, imem_req},   16'h0000);
        chk("rst_addr",  imem_addr,           16'h0100);
        chk("rst_pc",    pc_out,              16'h0100);
        chk("rst_valid", {15'd0, inst_valid}, 16'h0000);
        chk("rst_out",   inst_out,            16'h0000);
        chk("rst_ipc",   inst_pc,             16'h0000);

        // First fetch with decode stalled
        tick(); reset_n = 1'b1; #1;
        chk("f0_req",  {15'd0, imem_req}, 16'h0001);
        chk("f0_addr", imem_addr,         16'h0100);
        tick(); #1;
        chk("f0_wait_req", {15'd0, imem_req}, 16'h0000);
        chk("f0_wait_pc",  pc_out,            16'h0102);
        tick(); #1;
        chk("f0_valid", {15'd0, inst_valid}, 16'h0001);
        chk("f0_out",   inst_out,            16'h5B00);
        chk("f0_ipc",   inst_pc,             16'h0100);
        chk("bp_req0",  {15'd0, imem_req},   16'h0000);
        tick(); tick(); #1;
        chk("bp_req1", {15'd0, imem_req},   16'h0000);
        chk("bp_pc",   pc_out,              16'h0102);
        chk("bp_out",  inst_out,            16'h5B00);
        chk("bp_vld",  {15'd0, inst_valid}, 16'h0001);

        // Release backpressure: steady stream
        tick(); inst_ready = 1'b1; #1;
        chk("f1_req",  {15'd0, imem_req}, 16'h0001);
        chk("f1_addr", imem_addr,         16'h0102);
        tick(); #1;
        chk("f1_drain", {15'd0, inst_valid}, 16'h0000);
        chk("f1_pc",    pc_out,              16'h0104);
        tick(); #1;
        chk("f1_out",  inst_out,          16'h5B02);
        chk("f1_ipc",  inst_pc,           16'h0102);
        chk("f2_req",  {15'd0, imem_req}, 16'h0001);
        chk("f2_addr", imem_addr,         16'h0104);
        tick(); tick(); #1;
        chk("f2_out",  inst_out,  16'h5B04);
        chk("f2_ipc",  inst_pc,   16'h0104);
        chk("f3_addr", imem_addr, 16'h0106);

        // Branch 0x0040 + 0xFFF8 -> 0x0038, squashing an undrained buffer
        br_taken = 1'b1; br_base = 16'h0040; br_offset_sh = 16'hFFF8; inst_ready = 1'b0; #1;
        chk("br_req_block", {15'd0, imem_req}, 16'h0000);
        tick(); br_taken = 1'b0; inst_ready = 1'b1; #1;
        chk("br_squash", {15'd0, inst_valid}, 16'h0000);
        chk("br_addr",   imem_addr,           16'h0038);
        chk("br_req",    {15'd0, imem_req},   16'h0001);
        tick(); tick(); #1;
        chk("br_ipc", inst_pc,  16'h0038);
        chk("br_out", inst_out, 16'h5A38);

        // Branch while waiting on a 3-cycle response: response must be dropped
        lat = 3;
        tick(); #1;
        chk("wr_valid0", {15'd0, inst_valid}, 16'h0000);
        br_taken = 1'b1; br_base = 16'h0200; br_offset_sh = 16'h0010;
        tick(); br_taken = 1'b0; #1;
        chk("wr_req0", {15'd0, imem_req}, 16'h0000);
        chk("wr_pc",   pc_out,            16'h0210);
        tick(); #1;
        chk("wr_rvalid", {15'd0, imem_rvalid}, 16'h0001);
        chk("wr_valid1", {15'd0, inst_valid},  16'h0000);
        tick(); #1;
        chk("wr_valid2", {15'd0, inst_valid}, 16'h0000);
        chk("wr_req1",   {15'd0, imem_req},   16'h0001);
        chk("wr_addr",   imem_addr,           16'h0210);
        lat = 1;
        tick(); tick(); #1;
        chk("wr_ipc", inst_pc,  16'h0210);
        chk("wr_out", inst_out, 16'h5810);

        // Jump to 0xFFFE, check PC wrap, then jump+branch together
        jmp_valid = 1'b1; jmp_target = 16'hFFFE; #1;
        tick(); jmp_valid = 1'b0; #1;
        chk("jw_addr", imem_addr, 16'hFFFE);
        tick(); #1;
        chk("jw_wrap", pc_out, 16'h0000);
        tick(); #1;
        chk("jw_ipc", inst_pc,  16'hFFFE);
        chk("jw_out", inst_out, 16'hA5FE);
        jmp_valid = 1'b1; jmp_target = 16'h1235;
        br_taken = 1'b1; br_base = 16'h0040; br_offset_sh = 16'h0004;
        tick(); jmp_valid = 1'b0; br_taken = 1'b0; #1;
        chk("jp_addr",  imem_addr,           16'h1234);
        chk("jp_req",   {15'd0, imem_req},   16'h0001);
        chk("jp_valid", {15'd0, inst_valid}, 16'h0000);

        // Reset during WAIT_RSP, then a late rvalid
        lat = 3;
        tick(); reset_n = 1'b0; imem_gnt = 1'b0; #1;
        chk("mr_valid", {15'd0, inst_valid}, 16'h0000);
        chk("mr_out",   inst_out,            16'h0000);
        chk("mr_ipc",   inst_pc,             16'h0000);
        chk("mr_req",   {15'd0, imem_req},   16'h0000);
        chk("mr_addr",  imem_addr,           16'h0100);
        tick(); reset_n = 1'b1; #1;
        chk("mr_rel_req", {15'd0, imem_req}, 16'h0001);
        tick(); #1;
        chk("mr_late_rv", {15'd0, imem_rvalid}, 16'h0001);
        tick(); #1;
        chk("mr_late_ign", {15'd0, inst_valid}, 16'h0000);
        chk("mr_addr2",    imem_addr,           16'h0100);
        lat = 1; imem_gnt = 1'b1;
        tick(); tick(); #1;
        chk("mr_valid2", {15'd0, inst_valid}, 16'h0001);
        chk("mr_ipc2",   inst_pc,             16'h0100);
        chk("mr_out2",   inst_out,            16'h5B00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
